// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the unified byte-banked instruction/data memory between the
//   instruction-fetch port (IF, read only) and the load/store port (D).
//   Picks a winner in IDLE, drives address/data/enables to memory, waits the
//   fixed read latency, captures the word and pulses the owner's ack.
//
// Parameters
//   ADDR_W    byte address width
//   DATA_W    data word width
//   RD_LAT    cycles from mem_read_o rising to mem_rdata_i valid (1..4)
//   DATA_PRIO 1 = D port has fixed priority, 0 = round-robin
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req_i/if_addr_i       IF read request (level, held until ack) + address
//   if_ack_o/if_rdata_o      IF completion pulse, last word read for IF
//   d_req_i/d_we_i           D request (level) and write select
//   d_addr_i/d_wdata_i       D address and write data
//   d_ack_o/d_rdata_o        D completion pulse, last word read for D
//   mem_addr_o/mem_wdata_o   memory address and write data
//   mem_read_o/mem_write_o   memory read / write enables
//   mem_rdata_i              memory read data
//   busy_o                   high whenever an access is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int DATA_PRIO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // Two bits cover the largest legal RD_LAT (counter loads RD_LAT-1 <= 3).
   localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              winner;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      winner       = GNT_IF;

      case (state_q)
         S_IDLE: begin
            if (if_req_i || d_req_i) begin
               if (if_req_i && d_req_i)
                  // Round-robin hands the grant to whoever did not win last.
                  winner = (DATA_PRIO != 0) ? GNT_D : ~last_grant_q;
               else
                  winner = d_req_i ? GNT_D : GNT_IF;

               grant_d      = winner;
               last_grant_d = winner;
               cnt_d        = CNT_LOAD;
               if (winner == GNT_D) begin
                  mem_addr_d = d_addr_i;
                  if (d_we_i) begin
                     mem_wdata_d = d_wdata_i;
                     state_d     = S_WRITE;
                  end else begin
                     state_d = S_READ;
                  end
               end else begin
                  mem_addr_d = if_addr_i;
                  state_d    = S_READ;
               end
            end
         end
         S_READ: begin
            // Data is valid only on the last of the RD_LAT read cycles.
            if (cnt_q == 2'd0) begin
               if (grant_q == GNT_D) d_rdata_d  = mem_rdata_i;
               else                  if_rdata_d = mem_rdata_i;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_WRITE: state_d = S_DONE;
         default: state_d = S_IDLE;   // S_DONE: no back-to-back grant
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         grant_q      <= GNT_IF;
         last_grant_q <= GNT_IF;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // Enables and acks decode straight from state so an async reset clears
   // them in the same cycle, and READ/WRITE being distinct states keeps them
   // mutually exclusive.
   assign mem_read_o  = (state_q == S_READ);
   assign mem_write_o = (state_q == S_WRITE);
   assign if_ack_o    = (state_q == S_DONE) && (grant_q == GNT_IF);
   assign d_ack_o     = (state_q == S_DONE) && (grant_q == GNT_D);
   assign busy_o      = (state_q != S_IDLE);
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the unified byte-banked instruction/data memory of the multi-cycle CPU between two requesters: the instruction-fetch unit (IF port) and the load/store unit (D port).
- Arbitrates between the two and sequences each access: it drives memory address, write data and memread/memwrite, waits the fixed read latency, captures the returned word and acknowledges the requester.
- Sits between the CPU control FSM and the memory module.

Parameters:
- ADDR_W, 15: byte address width of all address ports.
- DATA_W, 32: data word width.
- RD_LAT, 1: cycles from mem_read first asserted to mem_rdata valid. Legal range 1..4.
- DATA_PRIO, 1: 1 = D port has fixed priority; 0 = round-robin.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; level, held until if_ack.
- if_addr  in  ADDR_W  IF byte address.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  last word read for IF.
- d_req  in  1  D request; level, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  D byte address.
- d_wdata  in  DATA_W  D write data.
- d_ack  out  1  one-cycle completion pulse to D.
- d_rdata  out  DATA_W  last word read for D.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, READ, WRITE, DONE. A grant flag records the owner (IF or D). last_grant holds the round-robin history.
- Reset (async, rst=1): state=IDLE, counter=0, last_grant=IF. All outputs are 0: if_ack, d_ack, if_rdata, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy. An access in progress is aborted immediately; mem_write drops while rst is high.
- Arbitration in IDLE, with only one request high: that request is granted.
- Arbitration with both requests high:
  - DATA_PRIO=1: D is granted.
  - DATA_PRIO=0: the port not equal to last_grant is granted. last_grant updates on each grant.
- Grant edge:
  - mem_addr and mem_wdata are latched from the winner (mem_wdata is only loaded on a D write).
  - Next state is READ for an IF request or a D request with d_we=0; WRITE for a D request with d_we=1.
  - The counter loads RD_LAT-1.
  - Requester inputs are ignored from this edge until its ack.
- READ: mem_read=1 for exactly RD_LAT cycles.
  - On the last READ cycle (counter=0), mem_rdata is captured into the owner's rdata register; then go to DONE.
  - The other port's rdata is unchanged.
- WRITE: mem_write=1 for exactly one cycle, then DONE. d_rdata is unchanged.
- DONE:
  - The owner's ack is 1 for this single cycle; rdata is valid during and after it.
  - mem_read=mem_write=0.
  - Next state is always IDLE; no back-to-back grant from DONE.
- Latency, request seen in IDLE at cycle 0:
  - Read: mem_read high in cycles 1..RD_LAT; ack in cycle RD_LAT+1.
  - Write: mem_write high in cycle 1; ack in cycle 2.
  - Next grant is possible in cycle RD_LAT+2 (read) or cycle 3 (write).
- Requester drops req mid-access: the access still completes, ack still pulses and rdata still updates.
- A requester holding req after its ack is treated as a new request in IDLE.
- mem_addr and mem_wdata hold their values through IDLE until the next grant.
- mem_read and mem_write are never simultaneously 1.
- if_ack and d_ack are never simultaneously 1.
- The counter width covers RD_LAT max (2 bits).

Test Plan:
- Reset: assert rst mid-simulation with random inputs -> all outputs 0 within the same cycle; state IDLE.
- IF read, RD_LAT=1: if_req=1, if_addr=0x0004, memory word at 0x0004 = 0x8C010004 -> mem_read high cycle 1, if_ack cycle 2, if_rdata=0x8C010004, d_rdata unchanged.
- Priority, DATA_PRIO=1: if_req and d_req rise together, D write addr=0x0010 data=0xDEADBEEF -> mem_write cycle 1, d_ack cycle 2; IF then granted, if_ack at cycle 5.
- Round-robin, DATA_PRIO=0, both requests held continuously, reads only -> grants alternate D, IF, D, IF (first grant D because last_grant=IF at reset); acks every 3 cycles with RD_LAT=1.
- Write then read back, RD_LAT=3:
  - D write 0x12345678 to 0x0020: d_ack at cycle 2.
  - D read 0x0020 granted on the next IDLE cycle (cycle 3): mem_read in cycles 4..6, d_ack at cycle 7, d_rdata=0x12345678.
- Reset mid-WRITE: rst pulsed while mem_write=1 -> mem_write=0 immediately, no ack, busy=0; the next request is served normally.
